// File: rtl/display_refresh_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : display_refresh_scheduler
//  Purpose  : Time-multiplexed 8-digit seven-segment refresh with per-slot
//             blanking, digit masking and frame-aligned double-buffered data.
//  Revision : 1.0  initial release
// ============================================================================
module display_refresh_scheduler #(
    parameter int PRESCALE = 100000,
    parameter int BLANK    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [7:0]  digit_en,
    input  logic [31:0] data_in,
    input  logic        load_req,
    output logic        load_ack,
    output logic [31:0] disp_data,
    output logic [7:0]  an,
    output logic [2:0]  seg_sel,
    output logic        blank,
    output logic        frame_start
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(PRESCALE - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       digit_q, digit_d;
    logic [31:0]      disp_data_q, disp_data_d;
    logic             load_ack_q, load_ack_d;
    logic [7:0]       an_q, an_d;
    logic [2:0]       seg_sel_q, seg_sel_d;
    logic             blank_q, blank_d;
    logic             frame_start_q, frame_start_d;

    logic             slot_end;
    logic             frame_end;
    logic             commit;
    logic             in_blank_d;
    logic             lit_d;

    // Counter/position advance; leaving IDLE always restarts at digit 0, cnt 0.
    always_comb begin
        cnt_d     = cnt_q;
        digit_d   = digit_q;
        slot_end  = (cnt_q == C_CNT_LAST);
        frame_end = (state_q != ST_IDLE) && (digit_q == 3'd7) && slot_end;
        if (!en || (state_q == ST_IDLE)) begin
            cnt_d   = '0;
            digit_d = 3'd0;
        end else if (slot_end) begin
            cnt_d   = '0;
            digit_d = digit_q + 3'd1;
        end else begin
            cnt_d   = cnt_q + CNT_W'(1);
        end
    end

    generate
        if (BLANK == 0) begin : g_no_blank
            assign in_blank_d = 1'b0;
        end else begin : g_blank
            assign in_blank_d = (cnt_d < CNT_W'(BLANK));
        end
    endgenerate

    // Outputs are decoded from next-state so they line up with the registered position.
    always_comb begin
        state_d       = ST_IDLE;
        lit_d         = 1'b0;
        an_d          = 8'hFF;
        seg_sel_d     = digit_d;
        blank_d       = 1'b1;
        frame_start_d = 1'b0;
        disp_data_d   = disp_data_q;
        load_ack_d    = 1'b0;

        if (en) begin
            state_d = in_blank_d ? ST_BLANK : ST_DRIVE;
        end
        lit_d = (state_d == ST_DRIVE) && digit_en[digit_d];
        if (lit_d) begin
            an_d = ~(8'h01 << digit_d);
        end
        blank_d       = ~lit_d;
        frame_start_d = (state_d != ST_IDLE) && (digit_d == 3'd0) && (cnt_d == '0);

        commit = load_req && !load_ack_q && (!en || frame_end);
        if (commit) begin
            disp_data_d = data_in;
            load_ack_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            digit_q       <= 3'd0;
            disp_data_q   <= 32'd0;
            load_ack_q    <= 1'b0;
            an_q          <= 8'hFF;
            seg_sel_q     <= 3'd0;
            blank_q       <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            digit_q       <= digit_d;
            disp_data_q   <= disp_data_d;
            load_ack_q    <= load_ack_d;
            an_q          <= an_d;
            seg_sel_q     <= seg_sel_d;
            blank_q       <= blank_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign load_ack    = load_ack_q;
    assign disp_data   = disp_data_q;
    assign an          = an_q;
    assign seg_sel     = seg_sel_q;
    assign blank       = blank_q;
    assign frame_start = frame_start_q;

endmodule
`default_nettype wire
